// File: rtl/dig_core_pkg.sv
// Shared definitions for the waveform-generator digital core.
// Contents: command opcodes, the error response byte, the default register-file depth,
// and the state encodings used by the frame parser and the UART PHY.
package dig_core_pkg;

  localparam logic [7:0] OP_WRITE = 8'hA1;
  localparam logic [7:0] OP_READ  = 8'hA2;
  localparam logic [7:0] RESP_ERR = 8'hEE;

  localparam int unsigned NUM_REGS_DFLT = 4;

  typedef enum logic [2:0] {
    StIdle,
    StGotCmd,
    StGotAddr,
    StExec,
    StResp
  } parser_state_e;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

  typedef enum logic {
    TxIdle,
    TxRun
  } tx_state_e;

endpackage

// File: rtl/dig_core_uart_phy.sv
// 16x-oversampled 8N1 UART receiver and transmitter.
// Ports:
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset (already synchronised on release)
//   rx_i        serial input, idle high (double-flopped here)
//   tx_start_i  one-cycle request to send tx_data_i (ignored while tx_busy_o)
//   tx_data_i   byte to send
//   tx_o        serial output, idle high
//   tx_busy_o   transmitter is shifting a frame
//   rx_valid_o  one-cycle pulse in the cycle the stop bit is sampled high
//   rx_data_o   last received byte, valid with rx_valid_o
module dig_core_uart_phy
  import dig_core_pkg::*;
#(
  parameter logic [15:0] DIVISOR = 16'd326
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  input  logic       tx_start_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_o,
  output logic       tx_busy_o,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o
);

  // ---------------- receiver ----------------
  logic        rx_meta_q, rx_sync_q;
  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_div_q, rx_div_d;
  logic [3:0]  rx_tick_q, rx_tick_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_tick;

  assign rx_tick = (rx_div_q == DIVISOR - 16'd1);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_div_d   = rx_tick ? 16'd0 : rx_div_q + 16'd1;
    rx_tick_d  = rx_tick ? rx_tick_q + 4'd1 : rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_o = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        // Oversample phase is restarted on every falling edge.
        rx_div_d  = 16'd0;
        rx_tick_d = 4'd0;
        if (!rx_sync_q) rx_state_d = RxStart;
      end
      RxStart: begin
        if (rx_tick && rx_tick_q == 4'd7) begin
          rx_tick_d = 4'd0;
          rx_bit_d  = 3'd0;
          // A start bit that is high again at mid-bit was a glitch.
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (rx_tick && rx_tick_q == 4'd15) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
          else rx_bit_d = rx_bit_q + 3'd1;
        end
      end
      RxStop: begin
        if (rx_tick && rx_tick_q == 4'd15) begin
          rx_valid_o = rx_sync_q;
          rx_state_d = RxIdle;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_div_q   <= '0;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_meta_q  <= rx_i;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_div_q   <= rx_div_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  assign rx_data_o = rx_shift_q;

  // ---------------- transmitter ----------------
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_div_q, tx_div_d;
  logic [3:0]  tx_tick_q, tx_tick_d;
  logic [3:0]  tx_bit_q, tx_bit_d;
  logic [8:0]  tx_shift_q, tx_shift_d;
  logic        tx_q, tx_d;
  logic        tx_tick;

  assign tx_tick = (tx_div_q == DIVISOR - 16'd1);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_div_d   = tx_tick ? 16'd0 : tx_div_q + 16'd1;
    tx_tick_d  = tx_tick ? tx_tick_q + 4'd1 : tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    unique case (tx_state_q)
      TxIdle: begin
        tx_d     = 1'b1;
        tx_div_d = 16'd0;
        if (tx_start_i) begin
          // Divider restarts here so the start bit is not delayed by an old phase.
          tx_shift_d = {1'b1, tx_data_i};
          tx_d       = 1'b0;
          tx_tick_d  = 4'd0;
          tx_bit_d   = 4'd0;
          tx_state_d = TxRun;
        end
      end
      TxRun: begin
        // tx_bit_q: 0 start, 1..8 data, 9 stop.
        if (tx_tick && tx_tick_q == 4'd15) begin
          if (tx_bit_q == 4'd9) begin
            tx_d       = 1'b1;
            tx_state_d = TxIdle;
          end else begin
            tx_d       = tx_shift_q[0];
            tx_shift_d = {1'b1, tx_shift_q[8:1]};
            tx_bit_d   = tx_bit_q + 4'd1;
          end
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_q <= TxIdle;
      tx_div_q   <= '0;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '1;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_div_q   <= tx_div_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  assign tx_o      = tx_q;
  assign tx_busy_o = (tx_state_q == TxRun);

endmodule

// File: rtl/dig_core_uart.sv
// Digital core of the waveform generator: 3-byte command frames (CMD, ADDR, DATA) arrive
// over an 8N1 UART, act on a small 8-bit register file, and one response byte is returned
// per valid frame. CMD 8'hA1 writes, 8'hA2 reads; out-of-range ADDR answers 8'hEE.
// Ports:
//   clk        system clock
//   rst_raw_n  asynchronous active-low reset; release is synchronised internally
//   rx_i       UART serial input, idle high
//   tx_o       UART serial output, idle high
//   debug_o    current value of register 0
// Build option: define DIG_CORE_TIMEOUT_EN to abandon a partial frame after TIMEOUT_CYC
// clock cycles without a new byte; otherwise the parser waits indefinitely.
module dig_core_uart
  import dig_core_pkg::*;
#(
  parameter logic [15:0] DIVISOR  = 16'd326,
  parameter int unsigned NUM_REGS = NUM_REGS_DFLT
`ifdef DIG_CORE_TIMEOUT_EN
  ,
  parameter logic [19:0] TIMEOUT_CYC = 20'd200000
`endif
) (
  input  logic       clk,
  input  logic       rst_raw_n,
  input  logic       rx_i,
  output logic       tx_o,
  output logic [7:0] debug_o
);

  localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [8:0] NumRegsW = 9'(NUM_REGS);

  // Reset asserts asynchronously, releases two clocks after rst_raw_n rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge rst_raw_n) begin
    if (!rst_raw_n) rst_sync_q <= 2'b00;
    else rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  logic       rx_valid, tx_start, tx_busy;
  logic [7:0] rx_data;
  logic [7:0] resp_q, resp_d;

  dig_core_uart_phy #(
    .DIVISOR(DIVISOR)
  ) u_phy (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .rx_i      (rx_i),
    .tx_start_i(tx_start),
    .tx_data_i (resp_q),
    .tx_o      (tx_o),
    .tx_busy_o (tx_busy),
    .rx_valid_o(rx_valid),
    .rx_data_o (rx_data)
  );

  parser_state_e state_q, state_d;
  logic [7:0]    cmd_q, addr_q, data_q;
  logic [7:0]    regs_q [NUM_REGS];
  logic [AW-1:0] addr_idx;
  logic          addr_ok, is_op, is_write, wr_en, timeout;

  assign is_op    = rx_valid && (rx_data == OP_WRITE || rx_data == OP_READ);
  assign is_write = (cmd_q == OP_WRITE);
  assign addr_idx = addr_q[AW-1:0];
  assign addr_ok  = ({1'b0, addr_q} < NumRegsW);
  assign wr_en    = (state_q == StExec) && addr_ok && is_write;

`ifdef DIG_CORE_TIMEOUT_EN
  logic [19:0] to_q, to_d;
  logic        waiting;

  assign waiting = (state_q == StGotCmd) || (state_q == StGotAddr);

  always_comb begin
    to_d = 20'd0;
    if (waiting) to_d = rx_valid ? 20'd0 : to_q + 20'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_q <= '0;
    else to_q <= to_d;
  end

  assign timeout = waiting && (to_q == TIMEOUT_CYC - 20'd1);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    tx_start = 1'b0;
    unique case (state_q)
      StIdle:    if (is_op) state_d = StGotCmd;
      StGotCmd: begin
        if (rx_valid) state_d = StGotAddr;
        else if (timeout) state_d = StIdle;
      end
      StGotAddr: begin
        if (rx_valid) state_d = StExec;
        else if (timeout) state_d = StIdle;
      end
      StExec:    state_d = StResp;
      StResp: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = StIdle;
        end
      end
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else state_q <= state_d;
  end

  always_comb begin
    resp_d = RESP_ERR;
    if (addr_ok) resp_d = is_write ? data_q : regs_q[addr_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      resp_q <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else begin
      if (state_q == StIdle && is_op) cmd_q <= rx_data;
      if (state_q == StGotCmd && rx_valid) addr_q <= rx_data;
      if (state_q == StGotAddr && rx_valid) data_q <= rx_data;
      if (state_q == StExec) resp_q <= resp_d;
      if (wr_en) regs_q[addr_idx] <= data_q;
    end
  end

  assign debug_o = regs_q[0];

endmodule

// File: tb/tb_dig_core_uart.sv
// Directed bench for dig_core_uart. A small divisor keeps UART frames short; a background
// monitor decodes tx_o into a byte queue that the directed sequence consumes.
module tb_dig_core_uart;

  localparam logic [15:0] DIV = 16'd2;
  localparam int BIT = 16 * 2;
  localparam logic [19:0] TO_CYC = 20'd1000;

  logic       clk = 1'b0;
  logic       rst_raw_n;
  logic       rx = 1'b1;
  logic       tx_o;
  logic [7:0] debug_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] rxq[$];

  always #10 clk = ~clk;

  dig_core_uart #(
    .DIVISOR (DIV),
    .NUM_REGS(4)
`ifdef DIG_CORE_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(TO_CYC)
`endif
  ) dut (
    .clk      (clk),
    .rst_raw_n(rst_raw_n),
    .rx_i     (rx),
    .tx_o     (tx_o),
    .debug_o  (debug_o)
  );

  // Response monitor: samples each bit at its middle, keeps bytes with a good stop bit.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge tx_o);
      repeat (BIT / 2) @(posedge clk);
      if (tx_o == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(posedge clk);
          b[i] = tx_o;
        end
        repeat (BIT) @(posedge clk);
        if (tx_o == 1'b1) rxq.push_back(b);
      end
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d);
    send_byte(c, 1'b1);
    send_byte(a, 1'b1);
    send_byte(d, 1'b1);
  endtask

  // Bounded wait for one response byte; an empty queue yields X so the caller's check fails.
  task automatic get_resp(output logic [7:0] b);
    int n = 0;
    while (rxq.size() == 0 && n < 15 * BIT) begin
      @(posedge clk);
      n++;
    end
    if (rxq.size() == 0) b = 8'hxx;
    else b = rxq.pop_front();
    @(negedge clk);
  endtask

  task automatic expect_quiet(input string tag);
    repeat (12 * BIT) @(posedge clk);
    @(negedge clk);
    chk(tag, 8'(rxq.size()), 8'd0);
  endtask

  initial begin
    logic [7:0] r;
    rst_raw_n = 1'b0;
    #500;
    chk("reset_tx", {7'd0, tx_o}, 8'd1);
    chk("reset_debug", debug_o, 8'h00);
    #500;
    rst_raw_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("idle_tx", {7'd0, tx_o}, 8'd1);

    // Write/read of register 2; register 0 untouched.
    send_frame(8'hA1, 8'h02, 8'h5A);
    get_resp(r);
    chk("t2_write_resp", r, 8'h5A);
    send_frame(8'hA2, 8'h02, 8'h00);
    get_resp(r);
    chk("t2_read_resp", r, 8'h5A);
    chk("t2_debug", debug_o, 8'h00);

    // Out-of-range address: error response, no register changes.
    send_frame(8'hA1, 8'h07, 8'h33);
    get_resp(r);
    chk("t3_err_resp", r, 8'hEE);
    chk("t3_debug", debug_o, 8'h00);
    send_frame(8'hA2, 8'h03, 8'h00);
    get_resp(r);
    chk("t3_reg3", r, 8'h00);
    send_frame(8'hA2, 8'h02, 8'h00);
    get_resp(r);
    chk("t3_reg2", r, 8'h5A);

    // Write register 0; visible on debug_o.
    send_frame(8'hA1, 8'h00, 8'h01);
    get_resp(r);
    chk("t1_resp", r, 8'h01);
    chk("t1_debug", debug_o, 8'h01);

    // Stray non-opcode byte is dropped before a read.
    send_byte(8'h00, 1'b1);
    send_frame(8'hA2, 8'h00, 8'hFF);
    get_resp(r);
    chk("t4_resp", r, 8'h01);
    expect_quiet("t4_single");

    // Opcode byte with a bad stop bit must not start a frame.
    send_byte(8'hA1, 1'b0);
    repeat (12 * BIT) @(negedge clk);
    send_frame(8'hA2, 8'h00, 8'h00);
    get_resp(r);
    chk("badstop_resp", r, 8'h01);

    // Reset mid-frame: partial frame lost, registers cleared, tx held high.
    send_byte(8'hA1, 1'b1);
    send_byte(8'h00, 1'b1);
    rst_raw_n = 1'b0;
    #1;
    chk("t5_tx_in_reset0", {7'd0, tx_o}, 8'd1);
    chk("t5_debug_in_reset", debug_o, 8'h00);
    repeat (5) @(negedge clk);
    chk("t5_tx_in_reset1", {7'd0, tx_o}, 8'd1);
    rst_raw_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("t5_tx_after_reset", {7'd0, tx_o}, 8'd1);
    chk("t5_no_resp", 8'(rxq.size()), 8'd0);
    send_frame(8'hA2, 8'h00, 8'h00);
    get_resp(r);
    chk("t5_resp", r, 8'h00);

`ifdef DIG_CORE_TIMEOUT_EN
    // A lone CMD times out, so the next A2 starts a fresh frame.
    send_byte(8'hA1, 1'b1);
    repeat (int'(TO_CYC) + 200) @(posedge clk);
    send_frame(8'hA2, 8'h00, 8'h00);
    get_resp(r);
    chk("t6_resp", r, 8'h00);
    expect_quiet("t6_single");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
